// File: rtl/plab4_net_router_adaptive_pkg.sv
// plab4_net_router_adaptive_pkg: route directions, bubble thresholds and ring hop distance
package plab4_net_router_adaptive_pkg;
   localparam logic [1:0] DIR_PREV = 2'd0;
   localparam logic [1:0] DIR_TERM = 2'd1;
   localparam logic [1:0] DIR_NEXT = 2'd2;
   localparam int BUBBLE_THRU = 1;
   localparam int BUBBLE_INJ = 2;
   function automatic int hop_dist(int dest, int id, int n);
      return ((dest % n) + n - id) % n;
   endfunction
   // equidistant ring traffic keeps its direction; injected traffic picks the emptier side
   function automatic logic [1:0] route_dir(int dest, int id, int n, int port, logic tie_next);
      int fwd;
      fwd = hop_dist(dest, id, n);
      return fwd == 0 ? DIR_TERM : 2 * fwd < n ? DIR_NEXT : 2 * fwd > n ? DIR_PREV :
         port == 0 ? DIR_NEXT : port == 2 ? DIR_PREV : tie_next ? DIR_NEXT : DIR_PREV;
   endfunction
endpackage

// File: rtl/plab4_net_router_adaptive_if.sv
// plab4_net_router_adaptive_if: val/rdy/msg network port
interface plab4_net_router_adaptive_if #(parameter int W = 22);
   logic val;
   logic rdy;
   logic [W-1:0] msg;
   modport master(output val, msg, input rdy);
   modport slave(input val, msg, output rdy);
endinterface

// File: rtl/plab4_net_router_adaptive_input_queue.sv
// plab4_net_router_adaptive_input_queue: circular FIFO with registered free-entry count
module plab4_net_router_adaptive_input_queue #(
   parameter int p_depth = 4,
   parameter int p_nbits = 22,
   localparam int c_free_nbits = $clog2(p_depth + 1),
   localparam int c_aw = $clog2(p_depth)
) (
   input  logic clk,
   input  logic reset,
   input  logic enq,
   input  logic [p_nbits-1:0] enq_msg,
   input  logic deq,
   output logic deq_val,
   output logic [p_nbits-1:0] deq_msg,
   output logic [c_free_nbits-1:0] num_free
);
   logic [p_nbits-1:0] mem [p_depth];
   logic [c_aw-1:0] wp, rp;
   assign deq_val = num_free != c_free_nbits'(p_depth);
   assign deq_msg = mem[rp];
   always_ff @(posedge clk)
      if (reset) begin
         wp <= '0;
         rp <= '0;
         num_free <= c_free_nbits'(p_depth);
      end else begin
         if (enq) begin
            mem[wp] <= enq_msg;
            wp <= wp == c_aw'(p_depth - 1) ? '0 : wp + 1'b1;
         end
         if (deq) rp <= rp == c_aw'(p_depth - 1) ? '0 : rp + 1'b1;
         if (enq != deq) num_free <= enq ? num_free - 1'b1 : num_free + 1'b1;
      end
endmodule

// File: rtl/plab4_net_router_adaptive.sv
// plab4_net_router_adaptive: 3-port ring router with credits, bubble injection and round-robin outputs
module plab4_net_router_adaptive
   import plab4_net_router_adaptive_pkg::*;
#(
   parameter int p_payload_nbits = 8,
   parameter int p_opaque_nbits = 8,
   parameter int p_srcdest_nbits = 3,
   parameter int p_router_id = 0,
   parameter int p_num_routers = 8,
   parameter int p_buf_depth = 4,
   localparam int c_free_nbits = $clog2(p_buf_depth + 1)
) (
   input  logic clk,
   input  logic reset,
   plab4_net_router_adaptive_if.slave in0,
   plab4_net_router_adaptive_if.slave in1,
   plab4_net_router_adaptive_if.slave in2,
   plab4_net_router_adaptive_if.master out0,
   plab4_net_router_adaptive_if.master out1,
   plab4_net_router_adaptive_if.master out2,
   input  logic [c_free_nbits-1:0] num_free_prev,
   input  logic [c_free_nbits-1:0] num_free_next,
   output logic [c_free_nbits-1:0] own_free_in0,
   output logic [c_free_nbits-1:0] own_free_in2
);
   localparam int c_w = p_payload_nbits + p_opaque_nbits + 2 * p_srcdest_nbits;
   logic [2:0] in_val, in_rdy, h_val, deq, out_val, out_rdy, lk;
   logic [c_w-1:0] in_msg [3];
   logic [c_w-1:0] h_msg [3];
   logic [c_free_nbits-1:0] free [3];
   logic [1:0] dir [3];
   logic [1:0] lk_dir [3];
   logic [1:0] ptr [3];
   logic [1:0] gnt [3];
   int j;
   assign in_val = {in2.val, in1.val, in0.val};
   assign in_msg = '{in0.msg, in1.msg, in2.msg};
   assign out_rdy = {out2.rdy, out1.rdy, out0.rdy};
   assign {in2.rdy, in1.rdy, in0.rdy} = in_rdy;
   assign {out2.val, out1.val, out0.val} = out_val;
   assign out0.msg = h_msg[gnt[0]];
   assign out1.msg = h_msg[gnt[1]];
   assign out2.msg = h_msg[gnt[2]];
   assign own_free_in0 = free[0];
   assign own_free_in2 = free[2];
   for (genvar i = 0; i < 3; i++) begin : g_q
      assign in_rdy[i] = free[i] != '0;
      plab4_net_router_adaptive_input_queue #(.p_depth(p_buf_depth), .p_nbits(c_w)) q (
         .clk, .reset, .enq(in_val[i] && in_rdy[i]), .enq_msg(in_msg[i]), .deq(deq[i]),
         .deq_val(h_val[i]), .deq_msg(h_msg[i]), .num_free(free[i])
      );
   end
   // a stalled grant is locked to its input/output so the offered head cannot change
   always_comb begin
      j = 0;
      for (int i = 0; i < 3; i++)
         dir[i] = lk[i] ? lk_dir[i] : route_dir(int'(h_msg[i][c_w-1 -: p_srcdest_nbits]),
            p_router_id, p_num_routers, i, num_free_next >= num_free_prev);
      for (int o = 0; o < 3; o++) begin
         gnt[o] = '0;
         out_val[o] = 1'b0;
         for (int k = 2; k >= 0; k--) begin
            j = (int'(ptr[o]) + k) % 3;
            if (h_val[j] && dir[j] == 2'(o) && (lk[j] || o == 1 ||
                int'(o == 0 ? num_free_prev : num_free_next) >= (j == 1 ? BUBBLE_INJ : BUBBLE_THRU))) begin
               gnt[o] = 2'(j);
               out_val[o] = 1'b1;
            end
         end
         for (int i = 0; i < 3; i++)
            if (h_val[i] && lk[i] && lk_dir[i] == 2'(o)) begin
               gnt[o] = 2'(i);
               out_val[o] = 1'b1;
            end
         if (reset) out_val[o] = 1'b0;
      end
      deq = '0;
      for (int o = 0; o < 3; o++)
         if (out_val[o] && out_rdy[o]) deq[gnt[o]] = 1'b1;
   end
   always_ff @(posedge clk)
      if (reset) begin
         lk <= '0;
         for (int i = 0; i < 3; i++) begin
            lk_dir[i] <= DIR_PREV;
            ptr[i] <= '0;
         end
      end else
         for (int o = 0; o < 3; o++)
            if (out_val[o]) begin
               lk[gnt[o]] <= !out_rdy[o];
               lk_dir[gnt[o]] <= 2'(o);
               if (out_rdy[o]) ptr[o] <= gnt[o] == 2'd2 ? 2'd0 : gnt[o] + 2'd1;
            end
endmodule

// File: tb/tb_plab4_net_router_adaptive.sv
// tb_plab4_net_router_adaptive: directed vector table plus corner sequences for router id 2 of 8
module tb_plab4_net_router_adaptive;
   localparam int W = 22;
   typedef struct { int port; int dest; int prev; int next; int exp; } vec_t;
   logic clk = 1'b0;
   logic rst;
   logic [2:0] iv, ordy, ov, ir;
   logic [W-1:0] imsg [3];
   logic [W-1:0] om [3];
   logic [2:0] nfp, nfn, f0, f2;
   int nvec = 0;
   int nerr = 0;
   vec_t vt [11];
   always #5 clk = ~clk;
   plab4_net_router_adaptive_if #(.W(W)) in0_if ();
   plab4_net_router_adaptive_if #(.W(W)) in1_if ();
   plab4_net_router_adaptive_if #(.W(W)) in2_if ();
   plab4_net_router_adaptive_if #(.W(W)) out0_if ();
   plab4_net_router_adaptive_if #(.W(W)) out1_if ();
   plab4_net_router_adaptive_if #(.W(W)) out2_if ();
   assign {in2_if.val, in1_if.val, in0_if.val} = iv;
   assign in0_if.msg = imsg[0];
   assign in1_if.msg = imsg[1];
   assign in2_if.msg = imsg[2];
   assign {out2_if.rdy, out1_if.rdy, out0_if.rdy} = ordy;
   assign ir = {in2_if.rdy, in1_if.rdy, in0_if.rdy};
   assign ov = {out2_if.val, out1_if.val, out0_if.val};
   assign om[0] = out0_if.msg;
   assign om[1] = out1_if.msg;
   assign om[2] = out2_if.msg;
   plab4_net_router_adaptive #(
      .p_payload_nbits(8), .p_opaque_nbits(8), .p_srcdest_nbits(3),
      .p_router_id(2), .p_num_routers(8), .p_buf_depth(4)
   ) dut (
      .clk(clk), .reset(rst), .in0(in0_if), .in1(in1_if), .in2(in2_if),
      .out0(out0_if), .out1(out1_if), .out2(out2_if),
      .num_free_prev(nfp), .num_free_next(nfn), .own_free_in0(f0), .own_free_in2(f2)
   );
   function automatic logic [W-1:0] mk(int d, int s, int pl);
      return {3'(d), 3'(s), 8'hA5, 8'(pl)};
   endfunction
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      iv = '0;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask
   initial begin
      vt[0] = '{1, 3, 4, 4, 2};
      vt[1] = '{2, 0, 4, 4, 0};
      vt[2] = '{0, 2, 4, 4, 1};
      vt[3] = '{1, 6, 3, 1, 0};
      vt[4] = '{1, 6, 1, 3, 2};
      vt[5] = '{1, 6, 2, 2, 2};
      vt[6] = '{0, 6, 4, 1, 2};
      vt[7] = '{2, 6, 4, 1, 0};
      vt[8] = '{0, 3, 4, 1, 2};
      vt[9] = '{1, 4, 4, 2, 2};
      vt[10] = '{1, 1, 2, 4, 0};
      rst = 1'b1;
      iv = '0;
      ordy = 3'b111;
      nfp = 3'd4;
      nfn = 3'd4;
      for (int i = 0; i < 3; i++) imsg[i] = '0;
      do_reset();
      @(negedge clk);
      chk("reset in_rdy", 32'(ir), 32'h7);
      chk("reset out_val", 32'(ov), 32'h0);
      chk("reset free0", 32'(f0), 32'd4);
      chk("reset free2", 32'(f2), 32'd4);
      for (int n = 0; n < 11; n++) begin
         @(posedge clk);
         #1 nfp = 3'(vt[n].prev);
         nfn = 3'(vt[n].next);
         iv[vt[n].port] = 1'b1;
         imsg[vt[n].port] = mk(vt[n].dest, vt[n].port, n);
         @(posedge clk);
         #1 iv = '0;
         @(negedge clk);
         chk($sformatf("v%0d out_val", n), 32'(ov), 32'(1 << vt[n].exp));
         chk($sformatf("v%0d out_msg", n), 32'(om[vt[n].exp]), 32'(mk(vt[n].dest, vt[n].port, n)));
         @(negedge clk);
         chk($sformatf("v%0d drained", n), 32'(ov), 32'h0);
      end
      @(posedge clk);
      #1 nfp = 3'd4;
      nfn = 3'd1;
      iv[1] = 1'b1;
      imsg[1] = mk(3, 1, 50);
      @(posedge clk);
      #1 iv = '0;
      @(negedge clk);
      chk("bubble blocked", 32'(ov), 32'h0);
      @(negedge clk);
      chk("bubble still blocked", 32'(ov), 32'h0);
      #1 nfn = 3'd2;
      #1 chk("bubble released val", 32'(ov), 32'h4);
      chk("bubble released msg", 32'(om[2]), 32'(mk(3, 1, 50)));
      @(negedge clk);
      chk("bubble drained", 32'(ov), 32'h0);
      nfn = 3'd4;
      do_reset();
      iv = 3'b011;
      imsg[0] = mk(4, 0, 0);
      imsg[1] = mk(4, 1, 0);
      for (int c = 0; c < 8; c++) begin
         @(posedge clk);
         #1;
         if (c < 3) begin
            imsg[0] = mk(4, 0, c + 1);
            imsg[1] = mk(4, 1, c + 1);
         end else iv = '0;
         @(negedge clk);
         chk($sformatf("rr%0d val", c), 32'(ov), 32'h4);
         chk($sformatf("rr%0d msg", c), 32'(om[2]), 32'(mk(4, c % 2, c / 2)));
      end
      @(negedge clk);
      chk("rr done", 32'(ov), 32'h0);
      do_reset();
      ordy = 3'b011;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1 iv[0] = 1'b1;
         imsg[0] = mk(4, 0, k);
         @(negedge clk);
         chk($sformatf("full%0d rdy", k), 32'(ir[0]), 32'(k < 4));
         chk($sformatf("full%0d free", k), 32'(f0), 32'(4 - k));
      end
      chk("full held val", 32'(ov), 32'h4);
      chk("full held msg", 32'(om[2]), 32'(mk(4, 0, 0)));
      @(posedge clk);
      #1 iv = '0;
      ordy = 3'b111;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("drain%0d msg", k), 32'(om[2]), 32'(mk(4, 0, k)));
         chk($sformatf("drain%0d free", k), 32'(f0), 32'(k));
      end
      @(negedge clk);
      chk("drain free", 32'(f0), 32'd4);
      chk("drain val", 32'(ov), 32'h0);
      @(posedge clk);
      #1 ordy = '0;
      iv = 3'b111;
      imsg[0] = mk(4, 0, 70);
      imsg[1] = mk(2, 1, 71);
      imsg[2] = mk(0, 2, 72);
      @(posedge clk);
      #1 iv = '0;
      @(negedge clk);
      chk("mid queued val", 32'(ov), 32'h7);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("mid in reset val", 32'(ov), 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      ordy = 3'b111;
      @(negedge clk);
      chk("mid free0", 32'(f0), 32'd4);
      chk("mid free2", 32'(f2), 32'd4);
      chk("mid in_rdy", 32'(ir), 32'h7);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("mid flushed%0d", k), 32'(ov), 32'h0);
         @(negedge clk);
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
